// File: rtl/stream_release_pkg.sv
// Shared widths, default sizing and the {last,keep,data} entry type for the stream release tracker.
package stream_release_pkg;

    localparam int DEF_DEPTH        = 16;
    localparam int DEF_STREAM_WIDTH = 32;
    localparam int DEF_KEEP_WIDTH   = 1;

    localparam int ENTRY_W = 1 + DEF_KEEP_WIDTH + DEF_STREAM_WIDTH;
    localparam int CNT_W   = $clog2(DEF_DEPTH + 1);
    localparam int PTR_W   = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic                        last;
        logic [DEF_KEEP_WIDTH-1:0]   keep;
        logic [DEF_STREAM_WIDTH-1:0] data;
    } entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int entry_width(input int keep_w, input int data_w);
        return 1 + keep_w + data_w;
    endfunction

endpackage

// File: rtl/stream_release_fifo.sv
// First-word fall-through FIFO: RAM array with registered read into a head register.
// fill counts every beat held, including the one sitting in the head register.
module stream_release_fifo
    import stream_release_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WIDTH-1:0]             rd_data,
    output logic [cnt_width(DEPTH)-1:0]  fill,
    output logic                         empty
);

    localparam int CNT_BITS = cnt_width(DEPTH);
    localparam int PTR_BITS = ptr_width(DEPTH);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_BITS-1:0] mem_cnt_reg, mem_cnt_next;
    logic [CNT_BITS-1:0] fill_reg, fill_next;
    logic [WIDTH-1:0]    head_reg;
    logic                head_valid_reg;
    logic                wr_ready_reg;
    logic                wr_en, rd_en, head_load;

    assign wr_en     = wr_valid && wr_ready_reg;
    assign rd_en     = head_valid_reg && rd_ready;
    // Only beats already resident in RAM feed the head, which gives the one-cycle fall-through latency.
    assign head_load = (mem_cnt_reg != '0) && (!head_valid_reg || rd_en);

    always_comb begin
        fill_next    = fill_reg;
        mem_cnt_next = mem_cnt_reg;
        if (wr_en && !rd_en && fill_reg != FULL_CNT)
            fill_next = fill_reg + CNT_BITS'(1);
        else if (rd_en && !wr_en && fill_reg != '0)
            fill_next = fill_reg - CNT_BITS'(1);
        if (wr_en && !head_load)
            mem_cnt_next = mem_cnt_reg + CNT_BITS'(1);
        else if (head_load && !wr_en)
            mem_cnt_next = mem_cnt_reg - CNT_BITS'(1);
    end

    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= wr_data;
        if (head_load)
            head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_cnt_reg    <= '0;
            fill_reg       <= '0;
            head_valid_reg <= 1'b0;
            wr_ready_reg   <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            if (head_load)
                rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            mem_cnt_reg  <= mem_cnt_next;
            fill_reg     <= fill_next;
            wr_ready_reg <= (fill_next != FULL_CNT);
            if (head_load)
                head_valid_reg <= 1'b1;
            else if (rd_en)
                head_valid_reg <= 1'b0;
        end
    end

    assign wr_ready = wr_ready_reg;
    assign rd_valid = head_valid_reg;
    assign rd_data  = head_reg;
    assign fill     = fill_reg;
    assign empty    = (fill_reg == '0);

endmodule

// File: rtl/stream_release_tracker.sv
// Exit-side tracker: buffers pipeline output and pulses sigRelease once per released beat.
// Define STREAM_RELEASE_EARLY_EN to release on FIFO write instead of on downstream consumption.
module stream_release_tracker
    import stream_release_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int STREAM_WIDTH = DEF_STREAM_WIDTH,
    parameter int KEEP_WIDTH   = DEF_KEEP_WIDTH
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         sigRelease,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         empty
);

    localparam int ENTRY_BITS = entry_width(KEEP_WIDTH, STREAM_WIDTH);

    logic [ENTRY_BITS-1:0] wr_entry, rd_entry;
    logic                  release_event;
    logic                  release_event_reg;
    logic                  sig_release_reg;

    assign wr_entry = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    stream_release_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .aclk     (aclk),
        .reset    (reset),
        .wr_valid (s_axis_tvalid),
        .wr_ready (s_axis_tready),
        .wr_data  (wr_entry),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready),
        .rd_data  (rd_entry),
        .fill     (fill),
        .empty    (empty)
    );

    assign m_axis_tlast = rd_entry[ENTRY_BITS-1];
    assign m_axis_tkeep = rd_entry[STREAM_WIDTH +: KEEP_WIDTH];
    assign m_axis_tdata = rd_entry[STREAM_WIDTH-1:0];

`ifdef STREAM_RELEASE_EARLY_EN
    assign release_event = s_axis_tvalid && s_axis_tready;
`else
    assign release_event = m_axis_tvalid && m_axis_tready;
`endif

    // Two stages: event captured at edge N, pulse visible after edge N+1; reset drops anything in flight.
    always_ff @(posedge aclk) begin
        if (reset) begin
            release_event_reg <= 1'b0;
            sig_release_reg   <= 1'b0;
        end else begin
            release_event_reg <= release_event;
            sig_release_reg   <= release_event_reg;
        end
    end

    assign sigRelease = sig_release_reg;

endmodule

// File: tb/tb_stream_release_tracker.sv
// Randomized bench for stream_release_tracker against a queue-based reference model.
module tb_stream_release_tracker;
    import stream_release_pkg::*;

    localparam int DEPTH = DEF_DEPTH;

    logic             aclk = 1'b0;
    logic             reset;
    logic             s_valid, s_ready, s_last;
    logic [31:0]      s_data;
    logic [0:0]       s_keep;
    logic             m_valid, m_ready, m_last;
    logic [31:0]      m_data;
    logic [0:0]       m_keep;
    logic             sig_release;
    logic [CNT_W-1:0] fill;
    logic             empty;

    typedef struct {
        entry_t e;
        int     wcyc;
    } ref_t;

    ref_t   ref_q[$];
    int     cyc, n_vec, n_err;
    bit     exp_release, exp_pending, exp_sready, exp_mvalid;
    int     exp_fill;
    entry_t exp_head;
    bit     last_s_hs, last_m_hs;

    stream_release_tracker #(.DEPTH(DEPTH), .STREAM_WIDTH(32), .KEEP_WIDTH(1)) dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .sigRelease    (sig_release),
        .fill          (fill),
        .empty         (empty)
    );

    always #5 aclk = ~aclk;

    // Advance one clock; the model decides handshakes from its own view of ready/valid.
    task automatic step();
        ref_t r;
        bit   s_hs, m_hs, ev;
        s_hs = !reset && s_valid && exp_sready;
        m_hs = !reset && m_ready && exp_mvalid;
        if (reset) begin
            ref_q.delete();
            exp_release = 1'b0;
            exp_pending = 1'b0;
            exp_sready  = 1'b0;
        end else begin
            if (m_hs) r = ref_q.pop_front();
            if (s_hs) begin
                r.e.last = s_last;
                r.e.keep = s_keep;
                r.e.data = s_data;
                r.wcyc   = cyc + 1;
                ref_q.push_back(r);
            end
`ifdef STREAM_RELEASE_EARLY_EN
            ev = s_hs;
`else
            ev = m_hs;
`endif
            exp_release = exp_pending;
            exp_pending = ev;
            exp_sready  = (ref_q.size() < DEPTH);
        end
        last_s_hs = s_hs;
        last_m_hs = m_hs;
        @(posedge aclk);
        cyc++;
        exp_fill   = ref_q.size();
        exp_mvalid = (ref_q.size() > 0) && (ref_q[0].wcyc < cyc);
        if (exp_mvalid) exp_head = ref_q[0].e;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
            n_vec++; if (sig_release !== 1'b0) begin n_err++; $display("FAIL reset_release: got %b want 0", sig_release); end
            n_vec++; if (fill !== '0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill); end
            n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
            n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        end
        reset = 1'b0;
        step();
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_ready: got %b want 1", s_ready); end
        n_vec++; if (sig_release !== 1'b0) begin n_err++; $display("FAIL post_reset_release: got %b want 0", sig_release); end
    endtask

    task automatic test_single_beat();
        int pulses = 0;
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 32'hA5A5A5A5; s_last = 1'b1; s_keep = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        pulses += int'(sig_release);
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_latency: m_valid got %b want 0", m_valid); end
        n_vec++; if (fill !== 1) begin n_err++; $display("FAIL single_fill: got %0d want 1", fill); end
        step();
        pulses += int'(sig_release);
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", m_valid); end
        n_vec++; if (m_data !== 32'hA5A5A5A5 || m_last !== 1'b1 || m_keep !== 1'b1)
            begin n_err++; $display("FAIL single_data: got %h/%b/%b want a5a5a5a5/1/1", m_data, m_last, m_keep); end
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(sig_release);
            n_vec++; if (sig_release !== exp_release) begin n_err++; $display("FAIL single_release step%0d: got %b want %b", i, sig_release, exp_release); end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", empty); end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_fill_overflow();
        int pulses = 0;
        int want;
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = $urandom(); s_last = 1'($urandom_range(0, 1)); s_keep = 1'($urandom_range(0, 1));
        for (int i = 0; i < 22; i++) begin
            if (i == 20) s_valid = 1'b0;
            step();
            pulses += int'(sig_release);
            if (last_s_hs) begin s_data = $urandom(); s_last = 1'($urandom_range(0, 1)); s_keep = 1'($urandom_range(0, 1)); end
            n_vec++; if (fill !== CNT_W'(exp_fill)) begin n_err++; $display("FAIL overflow_fill cyc%0d: got %0d want %0d", cyc, fill, exp_fill); end
        end
`ifdef STREAM_RELEASE_EARLY_EN
        want = DEPTH;
`else
        want = 0;
`endif
        n_vec++; if (fill !== CNT_W'(DEPTH)) begin n_err++; $display("FAIL overflow_full: got %0d want %0d", fill, DEPTH); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL overflow_s_ready: got %b want 0", s_ready); end
        n_vec++; if (pulses != want) begin n_err++; $display("FAIL overflow_pulses: got %0d want %0d", pulses, want); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = $urandom(); s_last = 1'($urandom_range(0, 1)); s_keep = 1'($urandom_range(0, 1));
        for (int i = 0; i < 18; i++) begin
            step();
            if (i >= 1 && i <= 16) pulses += int'(sig_release);
            if (last_s_hs) begin s_data = $urandom(); s_last = 1'($urandom_range(0, 1)); s_keep = 1'($urandom_range(0, 1)); end
            n_vec++; if (sig_release !== exp_release) begin n_err++; $display("FAIL b2b_release cyc%0d: got %b want %b", cyc, sig_release, exp_release); end
            n_vec++; if (m_valid !== exp_mvalid) begin n_err++; $display("FAIL b2b_valid cyc%0d: got %b want %b", cyc, m_valid, exp_mvalid); end
            if (exp_mvalid) begin
                n_vec++; if ({m_last, m_keep, m_data} !== exp_head)
                    begin n_err++; $display("FAIL b2b_data cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, m_last, m_keep, m_data, exp_head.last, exp_head.keep, exp_head.data); end
            end
        end
`ifndef STREAM_RELEASE_EARLY_EN
        n_vec++; if (pulses != 16) begin n_err++; $display("FAIL b2b_pulses: got %0d want 16", pulses); end
`endif
        s_valid = 1'b0;
        for (int i = 0; i < 60 && !(exp_fill == 0 && !exp_pending && !exp_release); i++) begin
            step();
            n_vec++; if ({m_valid, m_last, m_keep, m_data} !== {exp_mvalid, exp_mvalid ? exp_head : entry_t'(m_last ? {m_last, m_keep, m_data} : {m_last, m_keep, m_data})})
                begin n_err++; $display("FAIL drain_beat cyc%0d: got %b %h want %b %h", cyc, m_valid, m_data, exp_mvalid, exp_head.data); end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_random();
        int dut_pulses = 0, model_events = 0, s_cnt = 0, i = 0;
        bit prev_valid = 1'b0, prev_ready = 1'b0;
        logic [33:0] prev_beat = '0;
        s_valid = 1'b0;
        while (s_cnt < 1000 && i < 20000) begin
            if (!s_valid || last_s_hs) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data = $urandom(); s_last = 1'($urandom_range(0, 1)); s_keep = 1'($urandom_range(0, 1));
            end
            m_ready = 1'($urandom_range(0, 1));
            prev_valid = m_valid; prev_ready = m_ready; prev_beat = {m_last, m_keep, m_data};
            step();
            i++;
            s_cnt += int'(last_s_hs);
`ifdef STREAM_RELEASE_EARLY_EN
            model_events += int'(last_s_hs);
`else
            model_events += int'(last_m_hs);
`endif
            dut_pulses += int'(sig_release);
            n_vec++; if (fill !== CNT_W'(exp_fill) || fill > CNT_W'(DEPTH)) begin n_err++; $display("FAIL rnd_fill cyc%0d: got %0d want %0d", cyc, fill, exp_fill); end
            n_vec++; if (s_ready !== exp_sready) begin n_err++; $display("FAIL rnd_s_ready cyc%0d: got %b want %b", cyc, s_ready, exp_sready); end
            n_vec++; if (m_valid !== exp_mvalid) begin n_err++; $display("FAIL rnd_m_valid cyc%0d: got %b want %b", cyc, m_valid, exp_mvalid); end
            n_vec++; if (sig_release !== exp_release) begin n_err++; $display("FAIL rnd_release cyc%0d: got %b want %b", cyc, sig_release, exp_release); end
            n_vec++; if (empty !== (exp_fill == 0)) begin n_err++; $display("FAIL rnd_empty cyc%0d: got %b want %b", cyc, empty, exp_fill == 0); end
            if (exp_mvalid) begin
                n_vec++; if ({m_last, m_keep, m_data} !== exp_head)
                    begin n_err++; $display("FAIL rnd_data cyc%0d: got %b/%b/%h want %b/%b/%h", cyc, m_last, m_keep, m_data, exp_head.last, exp_head.keep, exp_head.data); end
            end
            if (prev_valid && !prev_ready) begin
                n_vec++; if (m_valid !== 1'b1 || {m_last, m_keep, m_data} !== prev_beat)
                    begin n_err++; $display("FAIL rnd_stability cyc%0d: got %b %h want 1 %h", cyc, m_valid, m_data, prev_beat); end
            end
        end
        n_vec++; if (s_cnt < 1000) begin n_err++; $display("FAIL rnd_budget: got %0d beats want 1000", s_cnt); end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
`ifndef STREAM_RELEASE_EARLY_EN
            model_events += int'(last_m_hs);
`endif
            dut_pulses += int'(sig_release);
        end
        n_vec++; if (dut_pulses != model_events) begin n_err++; $display("FAIL rnd_pulse_count: got %0d want %0d", dut_pulses, model_events); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 40 && exp_fill < 7; i++) begin
            s_data = $urandom(); s_last = 1'($urandom_range(0, 1)); s_keep = 1'($urandom_range(0, 1));
            step();
        end
        s_valid = 1'b0;
        repeat (3) step();
        n_vec++; if (fill !== CNT_W'(7)) begin n_err++; $display("FAIL mid_prefill: got %0d want 7", fill); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++; if (fill !== '0) begin n_err++; $display("FAIL mid_fill: got %0d want 0", fill); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", empty); end
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(sig_release);
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL mid_pulses: got %0d want 0", pulses); end
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_s_ready: got %b want 1", s_ready); end
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; m_ready = 1'b0;
        cyc = 0; n_vec = 0; n_err = 0;
        exp_release = 1'b0; exp_pending = 1'b0; exp_sready = 1'b0; exp_mvalid = 1'b0; exp_fill = 0;
        exp_head = '0; last_s_hs = 1'b0; last_m_hs = 1'b0;
        test_reset();
        test_single_beat();
        test_fill_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
